// File: rtl/stopwatch_ctrl_pkg.sv
// rtl/stopwatch_ctrl_pkg.sv - shared state encoding, default timing and BCD helper for the stopwatch
package stopwatch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_LAP   = 2'd3
    } sw_state_t;

    localparam int unsigned DEF_TICK_DIV   = 100_000_000;
    localparam int unsigned DEF_DEB_CYCLES = 1_000_000;

    // Two-digit BCD increment, 99 wraps to 00.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            if (v[7:4] == 4'd9) r = 8'h00;
            else                r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// rtl/stopwatch_ctrl_if.sv - button inputs and display outputs of the stopwatch controller
interface stopwatch_ctrl_if;
    logic       btn_ss;
    logic       btn_lap;
    logic       btn_clr;
    logic [7:0] data;
    logic       running;
    logic       lap_active;

    modport master (output btn_ss, btn_lap, btn_clr, input data, running, lap_active);
    modport slave  (input btn_ss, btn_lap, btn_clr, output data, running, lap_active);
endinterface

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// rtl/stopwatch_ctrl_btn_debounce.sv - 2-FF sync + stability counter debouncer with rising-edge pulse
module btn_debounce
    import stopwatch_ctrl_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_rise
);
    localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic [CW-1:0] cnt;

    // Equality with the stable level wins over the terminal count, so a glitch
    // that ends exactly on the last count is still rejected.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            stable   <= 1'b0;
            cnt      <= '0;
            btn_rise <= 1'b0;
        end else begin
            sync1    <= btn_raw;
            sync2    <= sync1;
            btn_rise <= 1'b0;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                stable   <= sync2;
                cnt      <= '0;
                btn_rise <= sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign btn_level = stable;

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch FSM, prescaler, BCD seconds counter and display registers
module stopwatch_ctrl
    import stopwatch_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV   = DEF_TICK_DIV,
    parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    stopwatch_ctrl_if.slave  sw
);
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    logic ss_rise, lap_rise, clr_rise;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_ss  (
        .clk(clk), .rst(rst), .btn_raw(sw.btn_ss),  .btn_level(), .btn_rise(ss_rise));
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_lap (
        .clk(clk), .rst(rst), .btn_raw(sw.btn_lap), .btn_level(), .btn_rise(lap_rise));
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
        .clk(clk), .rst(rst), .btn_raw(sw.btn_clr), .btn_level(), .btn_rise(clr_rise));

    sw_state_t     state, state_nxt;
    logic [7:0]    count, count_nxt;
    logic [7:0]    latch, latch_nxt;
    logic [PW-1:0] presc, presc_nxt;
    logic          ev_ss, ev_lap, ev_clr;
    logic          active, tick;

    // Strict priority: a higher event claims the cycle even if the state ignores it.
    assign ev_clr = clr_rise;
    assign ev_ss  = ss_rise & ~clr_rise;
    assign ev_lap = lap_rise & ~ss_rise & ~clr_rise;

    assign active = (state == ST_RUN) || (state == ST_LAP);
    assign tick   = active && (presc == PRE_MAX);

    // Tick uses the current state's rule; the event only selects the next state.
    always_comb begin
        state_nxt = state;
        latch_nxt = latch;
        count_nxt = tick ? bcd_inc(count) : count;
        presc_nxt = active ? (tick ? '0 : presc + 1'b1) : presc;
        case (state)
            ST_IDLE: begin
                if (ev_ss) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (ev_ss) begin
                    state_nxt = ST_PAUSE;
                end else if (ev_lap) begin
                    state_nxt = ST_LAP;
                    latch_nxt = count;
                end
            end
            ST_LAP: begin
                if (ev_ss)       state_nxt = ST_PAUSE;
                else if (ev_lap) state_nxt = ST_RUN;
            end
            ST_PAUSE: begin
                if (ev_ss) begin
                    state_nxt = ST_RUN;
                end else if (ev_clr) begin
                    state_nxt = ST_IDLE;
                    count_nxt = 8'h00;
                    presc_nxt = '0;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            count         <= 8'h00;
            latch         <= 8'h00;
            presc         <= '0;
            sw.data       <= 8'h00;
            sw.running    <= 1'b0;
            sw.lap_active <= 1'b0;
        end else begin
            state         <= state_nxt;
            count         <= count_nxt;
            latch         <= latch_nxt;
            presc         <= presc_nxt;
            sw.data       <= (state_nxt == ST_LAP) ? latch_nxt : count_nxt;
            sw.running    <= (state_nxt == ST_RUN) || (state_nxt == ST_LAP);
            sw.lap_active <= (state_nxt == ST_LAP);
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - table-driven directed bench for stopwatch_ctrl (TICK_DIV=4, DEB_CYCLES=3)
module tb_stopwatch_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stopwatch_ctrl_if sw_if ();

    stopwatch_ctrl #(.TICK_DIV(4), .DEB_CYCLES(3)) dut (
        .clk (clk),
        .rst (rst),
        .sw  (sw_if)
    );

    typedef struct {
        logic       ss;
        logic       lap;
        logic       clr;
        int         cyc;
        logic [7:0] exp_data;
        logic       exp_run;
        logic       exp_lap;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic void add(input logic s, input logic l, input logic c, input int n,
                                input logic [7:0] d, input logic r, input logic la);
        vec_t v;
        v.ss = s; v.lap = l; v.clr = c; v.cyc = n;
        v.exp_data = d; v.exp_run = r; v.exp_lap = la;
        tbl.push_back(v);
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] d, input logic r, input logic la);
        check({tag, ".data"},       sw_if.data,              d);
        check({tag, ".running"},    {7'd0, sw_if.running},    {7'd0, r});
        check({tag, ".lap_active"}, {7'd0, sw_if.lap_active}, {7'd0, la});
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // Times in comments are edges after reset release; RUN entered at 6, ticks every 4.
        add(1,0,0,   5, 8'h00,1'b0,1'b0);   // 5: pulse out, state still IDLE
        add(1,0,0,   1, 8'h00,1'b1,1'b0);   // 6: RUN
        add(1,0,0,   2, 8'h00,1'b1,1'b0);
        add(0,0,0,  37, 8'h09,1'b1,1'b0);   // 45
        add(0,0,0,   1, 8'h10,1'b1,1'b0);   // 46: 40 cycles in RUN
        add(0,0,0, 356, 8'h99,1'b1,1'b0);   // 402
        add(0,0,0,   3, 8'h99,1'b1,1'b0);
        add(0,0,0,   1, 8'h00,1'b1,1'b0);   // 406: wrap
        add(0,0,0,  16, 8'h04,1'b1,1'b0);   // 422
        add(0,1,0,   5, 8'h05,1'b1,1'b0);   // 427: lap pulse
        add(0,1,0,   1, 8'h05,1'b1,1'b1);   // 428: LAP, latched 05
        add(0,1,0,   2, 8'h05,1'b1,1'b1);
        add(0,0,0,  20, 8'h05,1'b1,1'b1);   // 450
        add(0,1,0,   5, 8'h05,1'b1,1'b1);   // 455: 7 ticks frozen
        add(0,1,0,   1, 8'h12,1'b1,1'b0);   // 456: live again
        add(0,1,0,   2, 8'h13,1'b1,1'b0);
        add(0,0,0,   2, 8'h13,1'b1,1'b0);
        add(0,0,1,   8, 8'h15,1'b1,1'b0);   // clr ignored in RUN
        add(0,0,0, 362, 8'h06,1'b1,1'b0);   // 830
        add(1,0,0,   6, 8'h07,1'b0,1'b0);   // 836: PAUSE
        add(1,0,0,   2, 8'h07,1'b0,1'b0);
        add(0,0,0,  20, 8'h07,1'b0,1'b0);   // held in PAUSE
        add(0,0,1,   5, 8'h07,1'b0,1'b0);
        add(0,0,1,   1, 8'h00,1'b0,1'b0);   // 864: IDLE
        add(0,0,1,   2, 8'h00,1'b0,1'b0);
        add(0,0,0,  10, 8'h00,1'b0,1'b0);
        add(1,0,0,   6, 8'h00,1'b1,1'b0);   // 882: RUN
        add(1,0,0,   2, 8'h00,1'b1,1'b0);
        add(0,0,0,   6, 8'h02,1'b1,1'b0);
        add(1,0,0,   6, 8'h03,1'b0,1'b0);   // 896: PAUSE
        add(1,0,0,   2, 8'h03,1'b0,1'b0);
        add(0,0,0,   8, 8'h03,1'b0,1'b0);
        add(1,0,1,   6, 8'h00,1'b0,1'b0);   // 912: ss+clr -> IDLE
        add(1,0,1,   2, 8'h00,1'b0,1'b0);
        add(0,0,0,   8, 8'h00,1'b0,1'b0);
        add(1,0,0,   2, 8'h00,1'b0,1'b0);   // 2-cycle glitch
        add(0,0,0,  10, 8'h00,1'b0,1'b0);
        add(1,0,0,   6, 8'h00,1'b1,1'b0);   // 940: RUN
        add(1,0,0,   2, 8'h00,1'b1,1'b0);
        add(0,0,0, 130, 8'h33,1'b1,1'b0);   // 1072
        add(0,0,0,   1, 8'h33,1'b1,1'b0);

        sw_if.btn_ss  = 1'b0;
        sw_if.btn_lap = 1'b0;
        sw_if.btn_clr = 1'b0;
        rst = 1'b1;
        step(2);
        check_all("reset", 8'h00, 1'b0, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            sw_if.btn_ss  = tbl[i].ss;
            sw_if.btn_lap = tbl[i].lap;
            sw_if.btn_clr = tbl[i].clr;
            step(tbl[i].cyc);
            check_all($sformatf("vec%0d", i), tbl[i].exp_data, tbl[i].exp_run, tbl[i].exp_lap);
        end

        // One-cycle reset mid-RUN with start/stop held across it.
        rst = 1'b1;
        sw_if.btn_ss = 1'b1;
        step(1);
        check_all("midrst", 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        step(5);
        check_all("held_pre", 8'h00, 1'b0, 1'b0);
        step(1);
        check_all("held_run", 8'h00, 1'b1, 1'b0);
        step(20);
        check_all("held_once", 8'h05, 1'b1, 1'b0);
        sw_if.btn_ss = 1'b0;
        step(10);
        check_all("held_rel", 8'h07, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
